regfile_wb_sched: RTL and testbench

//  Write-back scheduler for the 32x32 register bank. Arbitrates its single write port

---
 rtl/regfile_wb_sched.sv | 135 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates the register-bank write port between ALU and load
// results, and tracks in-flight destinations to flag RAW/WAW hazards at issue.
module regfile_wb_sched #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_rd,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_rd,
   input  logic [ADDR_W-1:0]        rs1,
   input  logic [ADDR_W-1:0]        rs2,
   output logic                     hazard,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [(2**ADDR_W)-1:0]   busy
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned NREG  = 2**ADDR_W;

   typedef enum logic {S_NORMAL, S_FORCE_ALU} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                w_alu_gnt, w_mem_gnt, w_xfer;
   logic [ADDR_W-1:0]   w_rd;
   logic [DATA_W-1:0]   w_data;
   logic                r_wr_en, w_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic [NREG-1:0]     r_busy, w_busy_nxt;
   logic                w_hazard, w_rs1_haz, w_rs2_haz, w_waw_haz;

   // Arbitration and starvation counter: mem has priority unless ALU has lost too often
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_alu_gnt   = 1'b0;
      w_mem_gnt   = 1'b0;
      if (!RST) begin
         case (r_state)
            S_NORMAL: begin
               w_mem_gnt = mem_valid;
               w_alu_gnt = alu_valid && !mem_valid;
               if (w_alu_gnt)
                  w_cnt_nxt = '0;
               else if (alu_valid)
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               if (w_cnt_nxt == CNT_W'(STARVE_MAX))
                  w_state_nxt = S_FORCE_ALU;
            end
            S_FORCE_ALU: begin
               w_alu_gnt   = alu_valid;
               w_mem_gnt   = mem_valid && !alu_valid;
               w_cnt_nxt   = '0;
               w_state_nxt = S_NORMAL;
            end
            default: w_state_nxt = S_NORMAL;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_NORMAL;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign w_xfer = w_alu_gnt || w_mem_gnt;
   assign w_rd   = w_alu_gnt ? alu_rd   : mem_rd;
   assign w_data = w_alu_gnt ? alu_data : mem_data;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_xfer && (w_rd != '0);
         if (w_xfer) begin
            r_wr_addr <= w_rd;
            r_wr_data <= w_data;
         end
      end
   end

   // Pending write is dropped when reset arrives on its bank-write edge
   assign w_wr_en = r_wr_en && !RST;

   assign w_rs1_haz = (rs1 != '0) && (r_busy[rs1] || (w_wr_en && (r_wr_addr == rs1)));
   assign w_rs2_haz = (rs2 != '0) && (r_busy[rs2] || (w_wr_en && (r_wr_addr == rs2)));
   assign w_waw_haz = (iss_rd != '0) && r_busy[iss_rd];
   assign w_hazard  = iss_valid && (w_rs1_haz || w_rs2_haz || w_waw_haz);

   // Scoreboard: a new issue to the same register overrides the retiring write
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_xfer)
         w_busy_nxt[w_rd] = 1'b0;
      if (iss_valid && !w_hazard && (iss_rd != '0))
         w_busy_nxt[iss_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign alu_ready = w_alu_gnt;
   assign mem_ready = w_mem_gnt;
   assign hazard    = w_hazard;
   assign wr_en     = w_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign busy      = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table for arbitration/scoreboard,
// hand sequences for reset behaviour, with a small bank model on the write port.
module tb_regfile_wb_sched;

   logic        CLK;
   logic        RST;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        iss_valid;
   logic [4:0]  iss_rd, rs1, rs2;
   logic        hazard, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] bank [32] = '{default: '0};

   regfile_wb_sched #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(3)) dut (
      .CLK(CLK), .RST(RST),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
      .hazard(hazard), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (wr_en) bank[wr_addr] <= wr_data;

   typedef struct {
      logic        av;  logic [4:0] ard; logic [31:0] adat;
      logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
      logic        iv;  logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
      logic        e_ar; logic e_mr; logic e_hz;
      logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic [31:0] e_busy;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   initial begin
      //          av ard adat          mv mrd mdat   iv ird r1 r2  ar mr hz  we wa wd            busy
      vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,   0, 0, 0, 0,  1, 0, 0,  1, 5, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1, 3, 32'h111,      1, 4, 32'h222, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h222,      32'h0};
      vecs[2]  = '{1, 3, 32'h111,      1, 4, 32'h222, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h222,      32'h0};
      vecs[3]  = '{1, 3, 32'h111,      1, 4, 32'h222, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h222,      32'h0};
      vecs[4]  = '{1, 3, 32'h111,      1, 4, 32'h222, 0, 0, 0, 0,  1, 0, 0,  1, 3, 32'h111,      32'h0};
      vecs[5]  = '{1, 3, 32'h111,      1, 4, 32'h222, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h222,      32'h0};
      vecs[6]  = '{1, 3, 32'h111,      1, 4, 32'h222, 0, 0, 0, 0,  0, 1, 0,  1, 4, 32'h222,      32'h0};
      vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0,  0, 0, 0,  0, 4, 32'h222,      32'h0};
      vecs[8]  = '{1, 1, 32'hA,        0, 0, 32'h0,   1, 7, 0, 0,  1, 0, 0,  1, 1, 32'hA,        32'h80};
      vecs[9]  = '{0, 0, 32'h0,        1, 7, 32'h77,  1, 0, 7, 0,  0, 1, 1,  1, 7, 32'h77,       32'h0};
      vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 0, 7, 0,  0, 0, 1,  0, 7, 32'h77,       32'h0};
      vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 0, 7, 0,  0, 0, 0,  0, 7, 32'h77,       32'h0};
      vecs[12] = '{1, 0, 32'h99,       0, 0, 32'h0,   0, 0, 0, 0,  1, 0, 0,  0, 0, 32'h99,       32'h0};
      vecs[13] = '{1, 9, 32'h9,        0, 0, 32'h0,   1, 9, 0, 0,  1, 0, 0,  1, 9, 32'h9,        32'h200};
      vecs[14] = '{0, 0, 32'h0,        1, 9, 32'h19,  1, 9, 0, 0,  0, 1, 1,  1, 9, 32'h19,       32'h0};
      vecs[15] = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 0, 0, 9,  0, 0, 1,  0, 9, 32'h19,       32'h0};

      // Reset held two cycles with both streams requesting
      idle_inputs();
      RST = 1; alu_valid = 1; mem_valid = 1; alu_rd = 2; mem_rd = 3;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      chk("rst_wr_en",     64'(wr_en),     64'd0);
      chk("rst_wr_addr",   64'(wr_addr),   64'd0);
      chk("rst_wr_data",   64'(wr_data),   64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      RST = 0;
      idle_inputs();
      @(posedge CLK); #1;

      for (int i = 0; i < NV; i++) begin
         alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
         mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdat;
         iss_valid = vecs[i].iv; iss_rd = vecs[i].ird; rs1 = vecs[i].r1; rs2 = vecs[i].r2;
         #4;
         chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
         chk($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
         chk($sformatf("v%0d_hazard", i),    64'(hazard),    64'(vecs[i].e_hz));
         @(posedge CLK); #1;
         chk($sformatf("v%0d_wr_en", i),   64'(wr_en),   64'(vecs[i].e_we));
         chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].e_wa));
         chk($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(vecs[i].e_wd));
         chk($sformatf("v%0d_busy", i),    64'(busy),    64'(vecs[i].e_busy));
      end
      idle_inputs();

      chk("bank_r5", 64'(bank[5]), 64'hDEADBEEF);
      chk("bank_r1", 64'(bank[1]), 64'hA);
      chk("bank_r7", 64'(bank[7]), 64'h77);
      chk("bank_r9", 64'(bank[9]), 64'h19);
      chk("bank_r0", 64'(bank[0]), 64'h0);

      // Reset arriving while an accepted result waits for its bank write
      alu_valid = 1; alu_rd = 12; alu_data = 32'hC; iss_valid = 1; iss_rd = 13;
      #4;
      chk("t6_alu_ready", 64'(alu_ready), 64'd1);
      @(posedge CLK); #1;
      chk("t6_wr_en_pre", 64'(wr_en), 64'd1);
      chk("t6_busy_pre",  64'(busy),  64'h2000);
      idle_inputs();
      RST = 1; alu_valid = 1; alu_rd = 14;
      #4;
      chk("t6_wr_en_rst",     64'(wr_en),     64'd0);
      chk("t6_alu_ready_rst", 64'(alu_ready), 64'd0);
      @(posedge CLK); #1;
      chk("t6_busy_post",    64'(busy),     64'd0);
      chk("t6_wr_addr_post", 64'(wr_addr),  64'd0);
      chk("t6_bank_r12",     64'(bank[12]), 64'd0);
      RST = 0;
      idle_inputs();
      @(posedge CLK); #1;
      chk("t6_wr_en_after", 64'(wr_en),     64'd0);
      chk("t6_bank_r12_2",  64'(bank[12]),  64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
